// File: rtl/rf_stream_if.sv
// rf_stream_if: command, RF read port and output stream of the RF stream reader.
interface rf_stream_if #(
    parameter int WIDTH = 6,
    parameter int AW    = 3
);
    logic             start;
    logic [AW-1:0]    start_addr;
    logic [AW:0]      count;
    logic             abort;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [AW-1:0]    out_addr;
    logic             busy;
    logic             done;
    modport master (
        input  start, start_addr, count, abort, rdata, out_ready,
        output raddr, out_valid, out_data, out_addr, busy, done
    );
    modport slave (
        output start, start_addr, count, abort, rdata, out_ready,
        input  raddr, out_valid, out_data, out_addr, busy, done
    );
endinterface

// File: rtl/rf_stream_reader.sv
// rf_stream_reader: walks a wrapping RF address range and streams each word out on valid/ready.
module rf_stream_reader #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input logic         clk,
    input logic         rst_n,
    rf_stream_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    state_t           state_q, state_d;
    logic [AW-1:0]    raddr_q, raddr_d, addr_q, addr_d;
    logic [AW:0]      rem_q, rem_d, cnt_sat;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d, done_q, done_d;
    logic             load, xfer, go, step, kill;
    assign cnt_sat = (bus.count > DEPTH_C) ? DEPTH_C : bus.count;
    assign load    = !valid_q || bus.out_ready;
    assign xfer    = valid_q && bus.out_ready;
    assign go      = (state_q == IDLE) && bus.start;
    assign step    = (state_q == READ) && load && !bus.abort;
    assign kill    = (state_q != IDLE) && bus.abort;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            raddr_q <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end
    // abort wins over any handshake in READ and DRAIN
    always_comb begin
        state_d = (state_q == IDLE) ? ((bus.start && cnt_sat != '0) ? READ : IDLE)
                : bus.abort         ? IDLE
                : (state_q == READ) ? ((load && rem_q == (AW+1)'(1)) ? DRAIN : READ)
                : (xfer ? IDLE : DRAIN);
    end
    always_comb begin
        raddr_d = go ? bus.start_addr : step ? raddr_q + 1'b1 : raddr_q;
        rem_d   = go ? cnt_sat : kill ? '0 : step ? rem_q - 1'b1 : rem_q;
        valid_d = kill ? 1'b0 : step ? 1'b1 : (state_q == DRAIN && xfer) ? 1'b0 : valid_q;
        data_d  = step ? bus.rdata : data_q;
        addr_d  = step ? raddr_q : addr_q;
        done_d  = (go && cnt_sat == '0) || (state_q == DRAIN && xfer && !bus.abort);
    end
    assign bus.raddr     = raddr_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_addr  = addr_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_rf_stream_reader.sv
// tb_rf_stream_reader: directed and randomized transfers checked against an address-range model.
module tb_rf_stream_reader;
    localparam int W = 6;
    localparam int D = 8;
    localparam int A = 3;
    typedef struct {
        logic [A-1:0] a;
        logic [W-1:0] d;
        int           c;
    } beat_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [W-1:0] rf [D];
    beat_t beats[$];
    int cyc = 0, done_cnt = 0, busy_cyc = 0, viol = 0;
    int tests = 0, fails = 0;
    logic hold = 1'b0;
    logic [A-1:0] ha = '0;
    logic [W-1:0] hd = '0;
    logic [5:0] pat = 6'b101001;
    always #5 clk = ~clk;
    rf_stream_if #(.WIDTH(W), .AW(A)) bus();
    assign bus.rdata = rf[bus.raddr];
    rf_stream_reader #(.WIDTH(W), .DEPTH(D), .AW(A)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    // beats are taken at negedge, before the edge that completes the handshake
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready && !bus.abort) beats.push_back('{bus.out_addr, bus.out_data, cyc});
            if (bus.done) done_cnt <= done_cnt + 1;
            if (bus.busy) busy_cyc <= busy_cyc + 1;
            if ((bus.done && bus.busy) || (hold && !(bus.out_valid && bus.out_addr == ha && bus.out_data == hd)))
                viol <= viol + 1;
            hold <= bus.out_valid && !bus.out_ready && !bus.abort;
            ha   <= bus.out_addr;
            hd   <= bus.out_data;
        end else begin
            hold <= 1'b0;
        end
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic run(input int sa, input int cnt, input int mode, input bit lat, input int restart);
        int n  = cnt > D ? D : cnt;
        int b0 = beats.size();
        int d0 = done_cnt;
        int y0 = busy_cyc;
        bit seen = 1'b0;
        bus.out_ready  = 1'b1;
        bus.start      = 1'b1;
        bus.start_addr = sa[A-1:0];
        bus.count      = cnt[A:0];
        tick;
        bus.start = 1'b0;
        if (lat) begin
            chk("lat_valid_low", bus.out_valid, 0);
            chk("lat_busy", bus.busy, 1);
        end
        for (int i = 0; i < 300 && !seen; i++) begin
            bus.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom % 2) : pat[i % 6];
            if (i == restart) begin
                bus.start      = 1'b1;
                bus.start_addr = 3'(sa + 3);
                bus.count      = 4'd2;
            end
            tick;
            bus.start = 1'b0;
            if (lat && i == 0) begin
                chk("lat_valid_high", bus.out_valid, 1);
                chk("lat_addr", bus.out_addr, sa % D);
                chk("lat_data", bus.out_data, rf[sa % D]);
            end
            seen = (done_cnt != d0);
        end
        bus.out_ready = 1'b1;
        repeat (3) tick;
        chk("done_seen", seen, 1);
        chk("done_once", done_cnt - d0, 1);
        chk("beat_count", beats.size() - b0, n);
        for (int k = 0; k < n && b0 + k < beats.size(); k++) begin
            chk("beat_addr", beats[b0+k].a, (sa + k) % D);
            chk("beat_data", beats[b0+k].d, rf[(sa + k) % D]);
            if (mode == 0 && k > 0) chk("no_bubble", beats[b0+k].c - beats[b0+k-1].c, 1);
        end
        if (n == 0) chk("busy_never", busy_cyc - y0, 0);
        chk("stable_hold", viol, 0);
    endtask
    initial begin
        int b0, d0;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.count      = '0;
        bus.abort      = 1'b0;
        bus.out_ready  = 1'b0;
        for (int i = 0; i < D; i++) rf[i] = 6'(i + 10);
        #3;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_raddr", bus.raddr, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_addr", bus.out_addr, 0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        run(2, 3, 0, 1'b1, -1);
        run(6, 4, 0, 1'b1, -1);
        run(1, 3, 2, 1'b0, -1);
        run(4, 0, 0, 1'b0, -1);
        run(3, 15, 0, 1'b1, -1);
        run(0, 5, 0, 1'b0, 2);
        d0 = done_cnt;
        b0 = beats.size();
        bus.out_ready  = 1'b1;
        bus.start      = 1'b1;
        bus.start_addr = 3'd5;
        bus.count      = 4'd6;
        tick;
        bus.start = 1'b0;
        repeat (3) tick;
        bus.abort = 1'b1;
        tick;
        bus.abort = 1'b0;
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_busy", bus.busy, 0);
        repeat (3) tick;
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_beats", beats.size() - b0, 2);
        chk("abort_last_addr", beats[beats.size()-1].a, 6);
        run(7, 3, 0, 1'b1, -1);
        bus.out_ready  = 1'b0;
        bus.start      = 1'b1;
        bus.start_addr = 3'd0;
        bus.count      = 4'd8;
        tick;
        bus.start = 1'b0;
        tick;
        tick;
        chk("pre_reset_valid", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", bus.out_valid, 0);
        chk("async_busy", bus.busy, 0);
        chk("async_done", bus.done, 0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        run(2, 3, 0, 1'b1, -1);
        repeat (10) begin
            for (int j = 0; j < D; j++) rf[j] = 6'($urandom);
            run(int'($urandom % D), int'($urandom % 16), 1, 1'b0, -1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
